// File: rtl/pipe_stage_buf_if.sv
// rtl/pipe_stage_buf_if.sv - upstream/downstream handshake bundle for pipe_stage_buf
interface pipe_stage_buf_if #(
    parameter int DATA_W = 128,
    parameter int PC_W   = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   in_pc;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   out_pc;
    logic [DATA_W-1:0] out_data;
    logic              out_bubble;

    modport slave (
        input  in_valid, in_pc, in_data, out_ready,
        output in_ready, out_valid, out_pc, out_data, out_bubble
    );

    modport master (
        output in_valid, in_pc, in_data, out_ready,
        input  in_ready, out_valid, out_pc, out_data, out_bubble
    );
endinterface

// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - pipeline stage register with skid buffer, flush-to-bubble and stall counter
module pipe_stage_buf #(
    parameter int DATA_W  = 128,
    parameter int PC_W    = 32,
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    pipe_stage_buf_if.slave    bus,
    output logic [STALL_W-1:0] stall_cnt
);
    // State bits are {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     main_pc_q, main_pc_d;
    logic [DATA_W-1:0]   main_data_q, main_data_d;
    logic                bubble_q, bubble_d;
    logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0]   skid_data_q, skid_data_d;
    logic                in_ready_q, in_ready_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                in_fire, out_fire, main_valid;

    assign main_valid = state_q[1];
    assign in_fire    = bus.in_valid & in_ready_q;
    assign out_fire   = main_valid & bus.out_ready;

    always_comb begin
        state_d     = state_q;
        main_pc_d   = main_pc_q;
        main_data_d = main_data_q;
        bubble_d    = bubble_q;
        skid_pc_d   = skid_pc_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            // Killed slot keeps a meaningful PC for downstream EPC logic.
            state_d     = EMPTY;
            main_data_d = '0;
            bubble_d    = 1'b1;
            if (!main_valid && bus.in_valid) begin
                main_pc_d = bus.in_pc;
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_pc_d   = bus.in_pc;
                        main_data_d = bus.in_data;
                        bubble_d    = 1'b0;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (out_fire && in_fire) begin
                        main_pc_d   = bus.in_pc;
                        main_data_d = bus.in_data;
                        bubble_d    = 1'b0;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire) begin
                        skid_pc_d   = bus.in_pc;
                        skid_data_d = bus.in_data;
                        state_d     = FULL;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_pc_d   = skid_pc_q;
                        main_data_d = skid_data_q;
                        bubble_d    = 1'b0;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = ~state_d[0];
        stall_d    = stall_q;
        if (main_valid && !bus.out_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            main_pc_q   <= '0;
            main_data_q <= '0;
            bubble_q    <= 1'b0;
            skid_pc_q   <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            main_pc_q   <= main_pc_d;
            main_data_q <= main_data_d;
            bubble_q    <= bubble_d;
            skid_pc_q   <= skid_pc_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = main_valid;
    assign bus.out_pc     = main_pc_q;
    assign bus.out_data   = main_data_q;
    assign bus.out_bubble = bubble_q;
    assign stall_cnt      = stall_q;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb/tb_pipe_stage_buf.sv - scoreboard bench for pipe_stage_buf against a two-deep FIFO model
module tb_pipe_stage_buf;
    localparam int DW = 128;
    localparam int PW = 32;
    localparam int SW = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [SW-1:0] stall_cnt;

    pipe_stage_buf_if #(.DATA_W(DW), .PC_W(PW)) bus ();

    pipe_stage_buf #(.DATA_W(DW), .PC_W(PW), .STALL_W(SW)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] data;
    } ent_t;

    ent_t exp_q[$];
    ent_t last_e;
    bit   exp_bubble;
    int   exp_stall;
    bit   started;
    bit   popped;
    bit   after_reset;
    int   n_tests;
    int   n_fail;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted entries form a FIFO of depth two; flush empties it.
    always @(posedge clk) begin
        int   old;
        ent_t e;
        if (reset) begin
            exp_q.delete();
            last_e      = '0;
            exp_bubble  = 1'b0;
            exp_stall   = 0;
            started     = 1'b1;
            after_reset = 1'b1;
        end else if (started) begin
            old = exp_q.size() + (popped ? 1 : 0);
            if (old > 0 && !bus.out_ready && exp_stall < SAT) exp_stall++;
            if (flush) begin
                e.pc   = (exp_q.size() > 0) ? exp_q[0].pc : (bus.in_valid ? bus.in_pc : last_e.pc);
                e.data = '0;
                last_e = e;
                exp_q.delete();
                exp_bubble = 1'b1;
            end else begin
                if (bus.in_valid && bus.in_ready) begin
                    e.pc   = bus.in_pc;
                    e.data = bus.in_data;
                    exp_q.push_back(e);
                end
                if (exp_q.size() > 0 && (old == 0 || popped)) exp_bubble = 1'b0;
            end
            after_reset = 1'b0;
        end
        popped = 1'b0;
    end

    // Monitor: compares what the DUT presents, pops on output handshakes.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", bus.in_ready, !after_reset && exp_q.size() < 2);
            chk("out_valid", bus.out_valid, exp_q.size() > 0);
            chk("out_bubble", bus.out_bubble, exp_bubble);
            chk("stall_cnt", stall_cnt, exp_stall);
            if (exp_q.size() > 0) begin
                chk("out_pc", bus.out_pc, exp_q[0].pc);
                chk("out_data", bus.out_data, exp_q[0].data);
            end else begin
                chk("idle_pc", bus.out_pc, last_e.pc);
                chk("idle_data", bus.out_data, last_e.data);
            end
            if (exp_q.size() > 0 && bus.out_ready && !flush && !reset) begin
                last_e = exp_q.pop_front();
                popped = 1'b1;
            end
        end
    end

    task automatic cyc(input bit iv, input logic [PW-1:0] pc, input bit ordy, input bit fl, input bit rst);
        bus.in_valid  = iv;
        bus.in_pc     = pc;
        bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
        bus.out_ready = ordy;
        flush         = fl;
        reset         = rst;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [PW-1:0] pc;
        n_tests = 0;
        n_fail  = 0;
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("reset_in_ready", bus.in_ready, 1'b0);
        cyc(0, 0, 1, 0, 0);
        chk("post_reset_in_ready", bus.in_ready, 1'b1);
        // Streaming
        cyc(1, 32'h3000, 1, 0, 0);
        cyc(1, 32'h3004, 1, 0, 0);
        cyc(1, 32'h3008, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("stream_stall", stall_cnt, 0);
        cyc(0, 0, 1, 0, 0);
        // Backpressure fill and drain
        cyc(1, 32'h3000, 0, 0, 0);
        cyc(1, 32'h3004, 0, 0, 0);
        chk("full_in_ready", bus.in_ready, 1'b0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("drained_in_ready", bus.in_ready, 1'b1);
        // Flush in FULL
        cyc(1, 32'h3010, 0, 0, 0);
        cyc(1, 32'h3014, 0, 0, 0);
        cyc(1, 32'h3018, 0, 1, 0);
        chk("flush_full_pc", bus.out_pc, 32'h3010);
        chk("flush_full_bubble", bus.out_bubble, 1'b1);
        cyc(0, 0, 1, 0, 0);
        // Flush when EMPTY, then reload
        cyc(1, 32'h4000, 1, 1, 0);
        chk("flush_empty_pc", bus.out_pc, 32'h4000);
        cyc(1, 32'h4004, 1, 0, 0);
        chk("reload_bubble", bus.out_bubble, 1'b0);
        cyc(0, 0, 1, 0, 0);
        // Saturation
        cyc(1, 32'h5000, 0, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
        chk("stall_sat", stall_cnt, SAT);
        cyc(0, 0, 0, 1, 0);
        chk("stall_after_flush", stall_cnt, SAT);
        cyc(0, 0, 0, 0, 1);
        chk("stall_after_reset", stall_cnt, 0);
        cyc(0, 0, 1, 0, 0);
        // Reset together with flush while FULL
        cyc(1, 32'h6000, 0, 0, 0);
        cyc(1, 32'h6004, 0, 0, 0);
        cyc(1, 32'h6008, 0, 1, 1);
        chk("rst_flush_bubble", bus.out_bubble, 1'b0);
        chk("rst_flush_in_ready", bus.in_ready, 1'b0);
        cyc(0, 0, 1, 0, 1);
        cyc(0, 0, 1, 0, 0);
        // Random traffic
        pc = 32'h8000;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) != 0,
                $urandom_range(0, 31) == 0, $urandom_range(0, 199) == 0);
            pc = pc + 32'd4;
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
